// File: rtl/vpu_wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vpu_wb_pkg - FSM states and skid-entry constants for vpu_result_writer
// rev 1.0
// ----------------------------------------------------------------------------
package vpu_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  localparam int DEF_W   = 8;
  localparam int DEF_P   = 64;
  localparam int ENTRY_W = DEF_P * DEF_W + DEF_P;

  // One skid entry is the result vector followed by its per-lane zero flags.
  function automatic int entry_width(input int p, input int w);
    return p * w + p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_wb_skid.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vpu_wb_skid - 2-entry skid FIFO holding {data, zero} result entries
// rev 1.0
// ----------------------------------------------------------------------------
module vpu_wb_skid
  import vpu_wb_pkg::*;
#(
  parameter int EW = ENTRY_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [EW-1:0]         push_data,
  input  logic                  pop,
  output logic [EW-1:0]         head,
  output logic                  empty,
  output logic                  full,
  output logic [SKID_CNT_W-1:0] count
);

  logic [EW-1:0]         mem_q [SKID_DEPTH];
  logic [EW-1:0]         mem_d [SKID_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == SKID_CNT_W'(SKID_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Single-bit pointers suffice because the depth is exactly two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/vpu_result_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vpu_result_writer - skid-buffered write-back of VPU result vectors to memory
// Optional: VPU_WB_ZERO_SKIP_EN masks zero lanes and skips all-zero vectors. rev 1.0
// ----------------------------------------------------------------------------
module vpu_result_writer
  import vpu_wb_pkg::*;
#(
  parameter int W  = 8,
  parameter int P  = 64,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW-1:0]   len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [P*W-1:0]  in_data,
  input  logic [P-1:0]    in_zero,
  input  logic            in_last,
  output logic            bm_we,
  input  logic            bm_ready,
  output logic [AW-1:0]   bm_addr,
  output logic [P*W-1:0]  bm_wdata,
  output logic [P-1:0]    bm_wmask,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int            EW      = entry_width(P, W);
  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);

  wb_state_e             state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW:0]           rem_q, rem_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;

  logic [EW-1:0]         skid_head;
  logic                  skid_empty, skid_full;
  logic [SKID_CNT_W-1:0] skid_count, count_next;
  logic                  accept, retire, head_skip;
  logic [P*W-1:0]        head_data;
  logic [P-1:0]          head_zero, head_mask;

  assign accept    = in_valid & in_ready_q & ~skid_full;
  assign head_data = skid_head[EW-1:P];
  assign head_zero = skid_head[P-1:0];

`ifdef VPU_WB_ZERO_SKIP_EN
  assign head_skip = &head_zero;
  assign head_mask = ~head_zero;
`else
  logic unused_zero;
  assign unused_zero = ^head_zero;
  assign head_skip   = 1'b0;
  assign head_mask   = '1;
`endif

  // An all-zero head retires without waiting for the memory port.
  assign retire     = ~skid_empty & (head_skip | bm_ready);
  assign count_next = skid_count + SKID_CNT_W'(accept) - SKID_CNT_W'(retire);

  vpu_wb_skid #(
    .EW(EW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({in_data, in_zero}),
    .pop       (retire),
    .head      (skid_head),
    .empty     (skid_empty),
    .full      (skid_full),
    .count     (skid_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    if (retire) begin
      addr_d = addr_q + AW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = base_addr;
          rem_d   = (len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, len};
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          rem_d = rem_q - REM_ONE;
          // A last flag must coincide exactly with the final counted beat.
          if (in_last != (rem_q == REM_ONE)) begin
            err_d = 1'b1;
          end
          if (in_last || (rem_q == REM_ONE)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (count_next == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_RUN) && (count_next < SKID_CNT_W'(SKID_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign bm_we    = ~skid_empty & ~head_skip;
  assign bm_addr  = addr_q;
  assign bm_wdata = skid_empty ? '0 : head_data;
  assign bm_wmask = skid_empty ? '0 : head_mask;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vpu_result_writer.sv
`default_nettype none
// tb_vpu_result_writer: randomized runs checked against a transaction-level model
// of the expected memory writes, run termination and error flag.
module tb_vpu_result_writer;

  localparam int W  = 8;
  localparam int P  = 64;
  localparam int AW = 10;
  localparam int DW = P * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len_i = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          bm_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [P-1:0]  in_zero = '0;
  logic          in_ready, bm_we, busy, done, err;
  logic [AW-1:0] bm_addr;
  logic [DW-1:0] bm_wdata;
  logic [P-1:0]  bm_wmask;

  vpu_result_writer #(.W(W), .P(P), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_zero(in_zero),
    .in_last(in_last), .bm_we(bm_we), .bm_ready(bm_ready), .bm_addr(bm_addr),
    .bm_wdata(bm_wdata), .bm_wmask(bm_wmask), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [P-1:0]  mask;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  wr_t obs_q[$];
  int  obs_cyc[$];
  int  done_total = 0;
  int  done_cyc = 0;
  int  occ = 0;
  int  occ_viol = 0;
  bit  occ_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records memory writes and done pulses, tracks buffer occupancy.
  always @(negedge clk) begin
    if (!rst || !busy) begin
      occ = 0;
    end else begin
      if (occ_en && in_ready && occ >= 2) occ_viol++;
      occ = occ + int'(in_valid && in_ready) - int'(bm_we && bm_ready);
    end
    if (rst && bm_we && bm_ready) begin
      obs_q.push_back('{bm_addr, bm_wdata, bm_wmask});
      obs_cyc.push_back(cyc);
    end
    if (rst && done) begin
      done_total++;
      done_cyc = cyc;
    end
  end

  logic [DW-1:0] beat_d [16];
  logic [P-1:0]  beat_z [16];
  wr_t exp_q[$];
  bit  exp_err;
  int  exp_n;

  task automatic gen_beat(input int i, input logic [P-1:0] z);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    for (int l = 0; l < P; l++) if (z[l]) d[l*W +: W] = '0;
    beat_d[i] = d;
    beat_z[i] = z;
  endtask

  function automatic logic [P-1:0] rand_zero();
    return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
  endfunction

  // Model: a run consumes beats until in_last or the length is exhausted; beat i lands at base+i.
  task automatic build_expected(input logic [AW-1:0] base, input logic [AW-1:0] len, input int last_pos);
    int len_eff;
    len_eff = (len == '0) ? (1 << AW) : int'(len);
    exp_n   = (last_pos != 0 && last_pos < len_eff) ? last_pos : len_eff;
    exp_err = (last_pos != len_eff);
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) begin
`ifdef VPU_WB_ZERO_SKIP_EN
      if (!(&beat_z[i])) exp_q.push_back('{AW'(int'(base) + i), beat_d[i], ~beat_z[i]});
`else
      exp_q.push_back('{AW'(int'(base) + i), beat_d[i], {P{1'b1}}});
`endif
    end
  endtask

  int rmode = 0;
  bit stall_seen, err_after_start, run_timeout;
  int ob0, d0, ov0, acc0_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0: bm_ready = 1'b1;
      1: bm_ready = ~bm_ready;
      2: bm_ready = 1'($urandom_range(0, 1));
      default: bm_ready = 1'b0;
    endcase
  endtask

  task automatic run(input logic [AW-1:0] base, input logic [AW-1:0] len, input int last_pos, input bit noisy);
    int i = 0;
    int budget = 400;
    bit acc;
    bit first = 1'b1;
    ob0 = obs_q.size(); d0 = done_total; ov0 = occ_viol;
    stall_seen = 1'b0; acc0_cyc = -1;
    start = 1'b1; base_addr = base; len_i = len;
    tick();
    start = 1'b0; base_addr = AW'($urandom); len_i = AW'($urandom);
    while (i < exp_n && budget > 0) begin
      in_valid = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = beat_d[i];
      in_zero  = beat_z[i];
      in_last  = (i + 1 == last_pos);
      if (noisy) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (first) begin err_after_start = err; first = 1'b0; end
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (acc && i == 0) acc0_cyc = cyc;
      tick();
      if (acc) i++;
      budget--;
    end
    // Keep offering junk after the run ends; none of it may be accepted.
    start = 1'b0; in_last = 1'b0; in_valid = 1'b1; in_data = ~beat_d[0]; in_zero = '0;
    while (done_total == d0 && budget > 0) begin tick(); budget--; end
    tick(); tick();
    in_valid = 1'b0;
    run_timeout = (budget == 0);
  endtask

  task automatic test_reset();
    int rdy_seen = 0;
    rst = 1'b0; rmode = 3;
    repeat (3) tick();
    checks++;
    if ({in_ready, bm_we, busy, done, err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000", {in_ready, bm_we, busy, done, err});
    end
    checks++;
    if ({bm_addr, bm_wdata, bm_wmask} !== '0) begin
      failures++; $display("FAIL reset_bus: got addr=%0h mask=%0h expected 0", bm_addr, bm_wmask);
    end
    rst = 1'b1;
    tick();
    ob0 = obs_q.size();
    in_valid = 1'b1; in_data = '1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready) rdy_seen++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (rdy_seen !== 0 || obs_q.size() !== ob0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_valid: got ready_cycles=%0d writes=%0d busy=%b expected 0 0 0",
                           rdy_seen, obs_q.size() - ob0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 4; i++) gen_beat(i, rand_zero());
    build_expected(10'h010, 10'd4, 4);
    rmode = 0; bm_ready = 1'b1;
    run(10'h010, 10'd4, 4, 1'b0);
    n = obs_q.size() - ob0;
    checks++;
    if (run_timeout || n !== 4) begin
      failures++; $display("FAIL b2b_count: got %0d writes timeout=%b expected 4", n, run_timeout);
    end
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[ob0+k] !== exp_q[k] || obs_cyc[ob0+k] !== acc0_cyc + 1 + k) begin
        failures++; $display("FAIL b2b_write%0d: got addr=%0h cyc=%0d expected addr=%0h cyc=%0d",
                             k, obs_q[ob0+k].addr, obs_cyc[ob0+k], exp_q[k].addr, acc0_cyc + 1 + k);
      end
    end
    checks++;
    if (n > 0 && done_cyc !== obs_cyc[ob0+n-1] + 1) begin
      failures++; $display("FAIL b2b_done_cyc: got %0d expected %0d", done_cyc, obs_cyc[ob0+n-1] + 1);
    end
    checks++;
    if (done_total - d0 !== 1 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_end: got done=%0d err=%b busy=%b expected 1 0 0", done_total - d0, err, busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    for (int i = 0; i < 4; i++) gen_beat(i, rand_zero());
    build_expected(10'h010, 10'd4, 4);
    rmode = 1; bm_ready = 1'b1;
    run(10'h010, 10'd4, 4, 1'b0);
    n = obs_q.size() - ob0;
    checks++;
    if (run_timeout || n !== exp_q.size()) begin
      failures++; $display("FAIL bp_count: got %0d writes timeout=%b expected %0d", n, run_timeout, exp_q.size());
    end
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[ob0+k] !== exp_q[k]) begin
        failures++; $display("FAIL bp_write%0d: got %0h expected %0h", k, obs_q[ob0+k], exp_q[k]);
      end
    end
    checks++;
    if (stall_seen !== 1'b1 || occ_viol - ov0 !== 0) begin
      failures++; $display("FAIL bp_ready: got stall=%b overfill=%0d expected 1 0", stall_seen, occ_viol - ov0);
    end
    checks++;
    if (done_total - d0 !== 1 || err !== 1'b0) begin
      failures++; $display("FAIL bp_end: got done=%0d err=%b expected 1 0", done_total - d0, err);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [AW-1:0] want [4];
    want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000; want[3] = 10'h001;
    for (int i = 0; i < 4; i++) gen_beat(i, rand_zero());
    build_expected(10'h3FE, 10'd4, 4);
    rmode = 2;
    run(10'h3FE, 10'd4, 4, 1'b0);
    n = obs_q.size() - ob0;
    checks++;
    if (run_timeout || n !== 4) begin
      failures++; $display("FAIL wrap_count: got %0d writes timeout=%b expected 4", n, run_timeout);
    end
    for (int k = 0; k < n && k < 4; k++) begin
      checks++;
      if (obs_q[ob0+k].addr !== want[k] || obs_q[ob0+k] !== exp_q[k]) begin
        failures++; $display("FAIL wrap_write%0d: got addr=%0h expected addr=%0h", k, obs_q[ob0+k].addr, want[k]);
      end
    end
  endtask

  task automatic test_length_mismatch();
    int n;
    for (int i = 0; i < 3; i++) gen_beat(i, rand_zero());
    build_expected(10'h100, 10'd3, 2);
    rmode = 2;
    run(10'h100, 10'd3, 2, 1'b0);
    n = obs_q.size() - ob0;
    checks++;
    if (run_timeout || n !== 2 || done_total - d0 !== 1 || err !== 1'b1) begin
      failures++; $display("FAIL early_last: got writes=%0d done=%0d err=%b expected 2 1 1", n, done_total - d0, err);
    end
    build_expected(10'h200, 10'd3, 0);
    run(10'h200, 10'd3, 0, 1'b0);
    n = obs_q.size() - ob0;
    checks++;
    if (run_timeout || n !== 3 || done_total - d0 !== 1 || err !== 1'b1) begin
      failures++; $display("FAIL missing_last: got writes=%0d done=%0d err=%b expected 3 1 1", n, done_total - d0, err);
    end
    for (int i = 0; i < 2; i++) gen_beat(i, rand_zero());
    build_expected(10'h050, 10'd2, 2);
    run(10'h050, 10'd2, 2, 1'b0);
    checks++;
    if (err_after_start !== 1'b0 || err !== 1'b0 || obs_q.size() - ob0 !== 2) begin
      failures++; $display("FAIL err_clear: got err_start=%b err_end=%b writes=%0d expected 0 0 2",
                           err_after_start, err, obs_q.size() - ob0);
    end
  endtask

  task automatic test_random();
    int n, ln, lp;
    logic [AW-1:0] b;
    for (int r = 0; r < 8; r++) begin
      b  = AW'($urandom);
      ln = $urandom_range(1, 12);
      lp = $urandom_range(0, ln + 1);
      for (int i = 0; i < ln; i++) gen_beat(i, rand_zero());
      build_expected(b, AW'(ln), lp);
      rmode = $urandom_range(0, 2);
      run(b, AW'(ln), lp, 1'b1);
      n = obs_q.size() - ob0;
      checks++;
      if (run_timeout || n !== exp_q.size() || done_total - d0 !== 1 || err !== exp_err || occ_viol - ov0 !== 0) begin
        failures++; $display("FAIL rand%0d_run: got writes=%0d done=%0d err=%b overfill=%0d expected %0d 1 %b 0",
                             r, n, done_total - d0, err, occ_viol - ov0, exp_q.size(), exp_err);
      end
      for (int k = 0; k < n && k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[ob0+k] !== exp_q[k]) begin
          failures++; $display("FAIL rand%0d_write%0d: got %0h expected %0h", r, k, obs_q[ob0+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_zero_flags();
    int n;
    int hit = -1;
    logic [AW-1:0] b;
    b = AW'($urandom);
    gen_beat(0, '0); gen_beat(1, '1); gen_beat(2, 64'hF); gen_beat(3, '0);
    build_expected(b, 10'd4, 4);
    rmode = 0; bm_ready = 1'b1; occ_en = 1'b0;
    run(b, 10'd4, 4, 1'b0);
    occ_en = 1'b1;
    n = obs_q.size() - ob0;
    for (int k = 0; k < n; k++) if (obs_q[ob0+k].addr == b + AW'(2)) hit = ob0 + k;
`ifdef VPU_WB_ZERO_SKIP_EN
    checks++;
    if (run_timeout || n !== 3 || obs_q[ob0+1].addr !== b + AW'(2)) begin
      failures++; $display("FAIL zskip_count: got writes=%0d second_addr=%0h expected 3 %0h",
                           n, obs_q[ob0+1].addr, b + AW'(2));
    end
    checks++;
    if (hit < 0 || obs_q[hit].mask !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      failures++; $display("FAIL zskip_mask: got %0h expected fffffffffffffff0", (hit < 0) ? '0 : obs_q[hit].mask);
    end
`else
    checks++;
    if (run_timeout || n !== 4 || hit < 0 || obs_q[hit].mask !== {P{1'b1}}) begin
      failures++; $display("FAIL zero_ignored: got writes=%0d expected 4 with full masks", n);
    end
`endif
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[ob0+k] !== exp_q[k]) begin
        failures++; $display("FAIL zero_write%0d: got %0h expected %0h", k, obs_q[ob0+k], exp_q[k]);
      end
    end
    checks++;
    if (done_total - d0 !== 1 || err !== 1'b0) begin
      failures++; $display("FAIL zero_end: got done=%0d err=%b expected 1 0", done_total - d0, err);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    gen_beat(0, '0);
    rmode = 3; bm_ready = 1'b0;
    ob0 = obs_q.size();
    start = 1'b1; base_addr = 10'h123; len_i = 10'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = beat_d[0]; in_zero = '0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (bm_we !== 1'b1 || bm_addr !== 10'h123 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_buffered: got we=%b addr=%0h busy=%b expected 1 123 1", bm_we, bm_addr, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, bm_we, busy, done, err} !== 5'b0 || {bm_addr, bm_wdata, bm_wmask} !== '0) begin
      failures++; $display("FAIL mid_reset: got ctrl=%b addr=%0h mask=%0h expected 0 0 0",
                           {in_ready, bm_we, busy, done, err}, bm_addr, bm_wmask);
    end
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) gen_beat(i, rand_zero());
    build_expected(10'h040, 10'd2, 2);
    rmode = 0; bm_ready = 1'b1;
    run(10'h040, 10'd2, 2, 1'b0);
    n = obs_q.size() - ob0;
    checks++;
    if (run_timeout || n !== 2 || err !== 1'b0 || done_total - d0 !== 1) begin
      failures++; $display("FAIL post_reset_run: got writes=%0d err=%b done=%0d expected 2 0 1", n, err, done_total - d0);
    end
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[ob0+k] !== exp_q[k]) begin
        failures++; $display("FAIL post_reset_write%0d: got %0h expected %0h", k, obs_q[ob0+k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_length_mismatch();
    test_random();
    test_zero_flags();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
